shift_seq: RTL and testbench
============================

SHIFT_SEQ -- requirements
Module: shift_seq

Interface
REQ-001 The block SHALL have parameter W, default 4, giving the data width of the driven shift register (minimum 2).
REQ-002 The block SHALL have parameter AW, default $clog2(W+1), giving the shift-amount width.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cmd_valid  input  1  a command is presented.
REQ-006 cmd_ready  output  1  the block accepts a command this cycle.
REQ-007 cmd_op  input  3  opcode: 0 LOAD, 1 CLEAR, 2 SHL, 3 SHR, 4 ROL, 5 ROR, 6 ASR, 7 SIN (serial shift-in).
REQ-008 cmd_amt  input  AW  shift count for opcodes 2-7.
REQ-009 cmd_data  input  W  load value for LOAD.
REQ-010 sin  input  1  serial fill bit for SIN, sampled each shift cycle.
REQ-011 q  input  W  current contents of the downstream shift register, fed back.
REQ-012 parallel  output  1  parallel-load select for the downstream register.
REQ-013 right  output  1  shift-direction select for the downstream register (1 = right).
REQ-014 L  output  1  bit entering the MSB on a right shift.
REQ-015 R  output  1  bit entering the LSB on a left shift.
REQ-016 DATA  output  W  parallel-load value.
REQ-017 busy  output  1  a command is in progress.
REQ-018 done  output  1  one-cycle completion pulse.

Function
REQ-019 Decoding: FSM states SHALL be IDLE, EXEC, DONE.
REQ-020 Acceptance: a command SHALL be accepted when cmd_valid and cmd_ready are both 1 on a rising edge.
REQ-021 Latching: opcode, data and the clamped amount SHALL be latched on acceptance, and the FSM SHALL enter EXEC.
REQ-022 Ready: cmd_ready SHALL be 1 only in IDLE.
REQ-023 Busy: busy SHALL be 1 in EXEC and DONE.
REQ-024 Hold: in IDLE and DONE the block SHALL drive parallel=1, DATA=q, so the downstream register holds its value; the downstream register has no hold mode.
REQ-025 LOAD/CLEAR: these SHALL spend exactly one EXEC cycle with parallel=1 and DATA=latched data (LOAD) or all zeros (CLEAR).
REQ-026 Shift count: shift ops SHALL spend exactly n EXEC cycles with parallel=0, where n = min(cmd_amt, W), decrementing an internal counter each cycle.
REQ-027 Fill bits, per op:
- SHL: right=0, R=0.
- SHR: right=1, L=0.
- ROL: right=0, R=q[W-1].
- ROR: right=1, L=q[0].
- ASR: right=1, L=q[W-1].
- SIN: right=1, L=sin.
- Unused fill bit: 0.
REQ-028 Zero count: a shift op with cmd_amt=0 SHALL spend one EXEC cycle in hold (parallel=1, DATA=q) and perform no shift.
REQ-029 Completion: after the last EXEC cycle the FSM SHALL enter DONE for exactly one cycle with done=1, then return to IDLE.
REQ-030 Latency: for a command accepted at edge t with effective count n≥1, shifts SHALL occur at edges t+1..t+n, done SHALL be high in cycle t+n+1, and cmd_ready SHALL be high again in cycle t+n+2.
REQ-031 Non-acceptance: cmd_valid while not ready SHALL be ignored, with no buffering.
REQ-032 Output form: outputs SHALL be combinational from FSM state, latched command and q; q SHALL NOT combinationally depend on block outputs within a cycle.

Reset
REQ-033 Reset SHALL force IDLE and clear the latched op, data and counter.
REQ-034 Reset SHALL force done=0, busy=0, cmd_ready=1 and hold outputs (parallel=1, DATA=q) in the following cycle.
REQ-035 Reset asserted during EXEC SHALL abort the command with no done pulse.
REQ-036 Reset SHALL take priority over a simultaneous command acceptance, which SHALL be discarded.

Structure
REQ-037 Opcode encodings and FSM state encodings SHALL be constants in the shared package shift_pkg.
REQ-038 Down-counting SHALL be a sub-module shift_cnt, with load value, decrement and zero flag.
REQ-039 The block SHALL contain no datapath register of width W other than the latched load data.

Verification (W=4, downstream shift register instanced with q looped back)
REQ-040 LOAD 4'b1011 -> q=1011 one edge after accept, done pulse next cycle, q then stable over 5 idle cycles.
REQ-041 ROR amt=1 from 1011 -> q=1101; then ASR amt=2 -> q=1111; then SHL amt=3 -> q=1000.
REQ-042 SHR amt=9 from 1111 -> clamped to 4 shifts, q=0000, done exactly 5 cycles after accept.
REQ-043 SIN amt=4 with sin sequence 1,0,1,1 -> q=1101; SHL amt=0 -> q unchanged, done 2 cycles after accept.
REQ-044 Reset asserted in 2nd EXEC cycle of SHL amt=4 from 0001 -> q=0100 at abort, no done pulse, cmd_ready=1 next cycle.
REQ-045 cmd_valid held high during a busy command -> no second accept until IDLE, then exactly one accept.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared constants for the shift sequencer.
// Holds the command opcode encodings, the FSM state encodings and a small
// helper that classifies opcodes as shift-type (counted) or single-cycle.
package shift_pkg;

    // Command opcodes presented on cmd_op.
    typedef enum logic [2:0] {
        OP_LOAD  = 3'd0,
        OP_CLEAR = 3'd1,
        OP_SHL   = 3'd2,
        OP_SHR   = 3'd3,
        OP_ROL   = 3'd4,
        OP_ROR   = 3'd5,
        OP_ASR   = 3'd6,
        OP_SIN   = 3'd7
    } op_e;

    // Sequencer states.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // True for opcodes that consume a shift count (everything but LOAD/CLEAR).
    function automatic logic is_shift_op(input op_e op);
        return (op != OP_LOAD) && (op != OP_CLEAR);
    endfunction

endpackage

// File: rtl/shift_cnt.sv
// Down-counter tracking the remaining shift cycles of a command.
// Ports:
//   clk        - clock, rising edge
//   reset      - synchronous active-high reset, clears the count
//   load_i     - load load_val_i (takes priority over dec_i)
//   load_val_i - value to load
//   dec_i      - decrement by one (ignored when already zero)
//   cnt_o      - current count
//   zero_o     - count is zero
module shift_cnt #(
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_i,
    input  logic [AW-1:0] load_val_i,
    input  logic          dec_i,
    output logic [AW-1:0] cnt_o,
    output logic          zero_o
);

    logic [AW-1:0] cnt_q;
    logic [AW-1:0] cnt_d;

    // Next-count selection: load, saturating decrement, or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != {AW{1'b0}})) begin
            cnt_d = cnt_q - {{(AW-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= {AW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == {AW{1'b0}});

endmodule

// File: rtl/shift_seq.sv
// Command sequencer driving an external shift register that has no hold mode.
// The register contents come back on q; every cycle the block either reloads
// q (hold), loads new data, or selects a shift direction and fill bit.
// Ports:
//   clk, reset            - clock and synchronous active-high reset
//   cmd_valid/cmd_ready   - command handshake (accepted when both high)
//   cmd_op/cmd_amt/cmd_data - opcode, shift count, load value
//   sin                   - serial fill bit for SIN
//   q                     - downstream register contents (fed back)
//   parallel/right/L/R/DATA - downstream register controls
//   busy/done             - command in progress / one-cycle completion pulse
module shift_seq
    import shift_pkg::*;
#(
    parameter int W  = 4,
    parameter int AW = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [AW-1:0] cmd_amt,
    input  logic [W-1:0]  cmd_data,
    input  logic          sin,
    input  logic [W-1:0]  q,
    output logic          parallel,
    output logic          right,
    output logic          L,
    output logic          R,
    output logic [W-1:0]  DATA,
    output logic          busy,
    output logic          done
);

    state_e        state_q;
    op_e           op_q;
    logic [W-1:0]  data_q;

    logic          accept_s;
    logic [AW-1:0] amt_clamped_s;
    logic [AW-1:0] cnt_s;
    logic          cnt_zero_s;
    logic          shift_op_s;
    logic          dec_s;
    logic          last_exec_s;

    assign cmd_ready     = (state_q == S_IDLE);
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);
    assign accept_s      = cmd_valid && cmd_ready;
    assign amt_clamped_s = (cmd_amt > AW'(W)) ? AW'(W) : cmd_amt;
    assign shift_op_s    = is_shift_op(op_q);

    // A shift op with a zero count sits in EXEC for one hold cycle only.
    assign dec_s       = (state_q == S_EXEC) && shift_op_s && !cnt_zero_s;
    assign last_exec_s = !shift_op_s || cnt_zero_s ||
                         (cnt_s == {{(AW-1){1'b0}}, 1'b1});

    shift_cnt #(.AW(AW)) u_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (accept_s),
        .load_val_i (amt_clamped_s),
        .dec_i      (dec_s),
        .cnt_o      (cnt_s),
        .zero_o     (cnt_zero_s)
    );

    // Sequencer FSM and command latch; reset wins over a same-edge accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= OP_LOAD;
            data_q  <= {W{1'b0}};
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept_s) begin
                        op_q    <= op_e'(cmd_op);
                        data_q  <= cmd_data;
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (last_exec_s) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Downstream register controls; the default is a parallel reload of q (hold).
    always_comb begin
        parallel = 1'b1;
        right    = 1'b0;
        L        = 1'b0;
        R        = 1'b0;
        DATA     = q;
        if (state_q == S_EXEC) begin
            case (op_q)
                OP_LOAD:  DATA = data_q;
                OP_CLEAR: DATA = {W{1'b0}};
                default: begin
                    if (!cnt_zero_s) begin
                        parallel = 1'b0;
                        case (op_q)
                            OP_SHL: begin right = 1'b0; R = 1'b0;   end
                            OP_SHR: begin right = 1'b1; L = 1'b0;   end
                            OP_ROL: begin right = 1'b0; R = q[W-1]; end
                            OP_ROR: begin right = 1'b1; L = q[0];   end
                            OP_ASR: begin right = 1'b1; L = q[W-1]; end
                            OP_SIN: begin right = 1'b1; L = sin;    end
                            default: begin right = 1'b0; end
                        endcase
                    end else begin
                        parallel = 1'b1;
                    end
                end
            endcase
        end else begin
            DATA = q;
        end
    end

endmodule

// File: tb/tb_shift_seq.sv
module tb_shift_seq;
    import shift_pkg::*;

    localparam int W  = 4;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_op = 3'd0;
    logic [AW-1:0] cmd_amt = '0;
    logic [W-1:0]  cmd_data = '0;
    logic          sin = 1'b0;
    logic [W-1:0]  q = 4'b0000;
    logic          parallel, right, L, R, busy, done;
    logic [W-1:0]  DATA;

    int n_checks = 0;
    int n_errors = 0;

    shift_seq #(.W(W), .AW(AW)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_amt(cmd_amt), .cmd_data(cmd_data), .sin(sin),
        .q(q), .parallel(parallel), .right(right), .L(L), .R(R),
        .DATA(DATA), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Downstream shift register: parallel load or one-bit shift, no hold mode.
    always @(posedge clk) begin
        if (parallel)   q <= DATA;
        else if (right) q <= {L, q[W-1:1]};
        else            q <= {q[W-2:0], R};
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one command for exactly one edge; returns in cycle t+1.
    task automatic send(input logic [2:0] op, input logic [AW-1:0] amt, input logic [W-1:0] d);
        cmd_op = op; cmd_amt = amt; cmd_data = d; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    // Cycle number (relative to the accept edge) in which done is seen; 20 = timeout.
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!done && cyc < 20) begin
            step();
            cyc++;
        end
    endtask

    task automatic run_cmd(input string tag, input logic [2:0] op, input logic [AW-1:0] amt,
                           input logic [W-1:0] d, input logic [W-1:0] exp_q, input int exp_lat);
        int cyc;
        send(op, amt, d);
        wait_done(cyc);
        check_val({tag, "_lat"}, cyc, exp_lat);
        check_val({tag, "_q"}, q, exp_q);
        step();
        check_val({tag, "_ready"}, cmd_ready, 1'b1);
        check_val({tag, "_done_pulse"}, done, 1'b0);
    endtask

    initial begin
        int cyc;
        int ndone;
        repeat (2) step();
        reset = 1'b0;
        check_val("rst_ready", cmd_ready, 1'b1);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_done", done, 1'b0);
        check_val("rst_parallel", parallel, 1'b1);
        check_val("rst_data", DATA, 4'b0000);

        // LOAD 1011: exec cycle drives the latched data, then hold.
        send(3'(OP_LOAD), 4'd0, 4'b1011);
        check_val("load_busy", busy, 1'b1);
        check_val("load_ready", cmd_ready, 1'b0);
        check_val("load_data", DATA, 4'b1011);
        wait_done(cyc);
        check_val("load_lat", cyc, 2);
        check_val("load_q", q, 4'b1011);
        step();
        check_val("load_done_pulse", done, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            check_val("idle_hold_q", q, 4'b1011);
        end

        run_cmd("ror1", 3'(OP_ROR), 4'd1, 4'b0000, 4'b1101, 2);
        run_cmd("asr2", 3'(OP_ASR), 4'd2, 4'b0000, 4'b1111, 3);
        run_cmd("shl3", 3'(OP_SHL), 4'd3, 4'b0000, 4'b1000, 4);
        run_cmd("clear", 3'(OP_CLEAR), 4'd0, 4'b1010, 4'b0000, 2);
        run_cmd("load_f", 3'(OP_LOAD), 4'd0, 4'b1111, 4'b1111, 2);
        run_cmd("shr9", 3'(OP_SHR), 4'd9, 4'b0000, 4'b0000, 5);

        // SIN x4 with fill sequence 1,0,1,1 from 0000.
        send(3'(OP_SIN), 4'd4, 4'b0000);
        sin = 1'b1; step();
        sin = 1'b0; step();
        sin = 1'b1; step();
        sin = 1'b1; step();
        sin = 1'b0;
        check_val("sin_done", done, 1'b1);
        check_val("sin_q", q, 4'b1101);
        step();

        // Zero-count shift: one hold cycle in EXEC.
        send(3'(OP_SHL), 4'd0, 4'b0000);
        check_val("shl0_parallel", parallel, 1'b1);
        check_val("shl0_data", DATA, 4'b1101);
        wait_done(cyc);
        check_val("shl0_lat", cyc, 2);
        check_val("shl0_q", q, 4'b1101);
        step();

        run_cmd("rol1", 3'(OP_ROL), 4'd1, 4'b0000, 4'b1011, 2);
        run_cmd("load_1", 3'(OP_LOAD), 4'd0, 4'b0001, 4'b0001, 2);

        // Reset during the 2nd EXEC cycle of SHL x4.
        send(3'(OP_SHL), 4'd4, 4'b0000);
        step();
        reset = 1'b1;
        step();
        check_val("abort_q", q, 4'b0100);
        check_val("abort_ready", cmd_ready, 1'b1);
        check_val("abort_done", done, 1'b0);
        // Command presented while reset is still high must be discarded.
        cmd_op = 3'(OP_LOAD); cmd_data = 4'b1111; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        reset = 1'b0;
        check_val("rst_prio_busy", busy, 1'b0);
        ndone = 0;
        for (int i = 0; i < 4; i++) begin
            if (done) ndone++;
            step();
        end
        check_val("abort_no_done", ndone, 0);
        check_val("rst_prio_q", q, 4'b0100);

        // cmd_valid held high across a busy ROL x1: exactly two accepts.
        cmd_op = 3'(OP_ROL); cmd_amt = 4'd1; cmd_valid = 1'b1;
        step();
        check_val("hold_v_busy", busy, 1'b1);
        check_val("hold_v_ready0", cmd_ready, 1'b0);
        step();
        check_val("hold_v_done1", done, 1'b1);
        check_val("hold_v_q1", q, 4'b1000);
        step();
        check_val("hold_v_ready1", cmd_ready, 1'b1);
        step();
        cmd_valid = 1'b0;
        check_val("hold_v_busy2", busy, 1'b1);
        wait_done(cyc);
        check_val("hold_v_lat2", cyc, 2);
        check_val("hold_v_q2", q, 4'b0001);
        ndone = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (done || busy) ndone++;
        end
        check_val("hold_v_no_third", ndone, 0);
        check_val("hold_v_final_q", q, 4'b0001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
